// File: rtl/tx_frame_sched.sv
// tx_frame_sched: sequencing controller for the 10G TX frame generator on XGMII port 0.
// It decides when the generator starts each frame. It enforces the inter-frame gap and
// the burst length. Before test traffic starts, it can resolve the gateway MAC by ARP,
// with a timeout and retries.
//
// Ports:
//   sys_clk, sys_rst          clock and synchronous active-high reset
//   tx_enable                 level: run traffic while high (rising edge starts a new run)
//   tx_req_arp                level: resolve destination MAC by ARP before sending
//   inter_frame_gap           idle cycles between frame_done and the next frame_start
//   burst_count               frames per run, 0 = unlimited
//   arp_reply_valid/_mac      gateway ARP reply seen on RX, with sender MAC
//   arp_done, frame_done      generator finished the ARP request / IPv4 frame
//   sec_oneshot               once-per-second pulse (statistics only)
//   arp_start, frame_start    one-cycle start pulses to the generator
//   tx0_dst_mac, dst_mac_valid  resolved destination MAC (broadcast when unresolved)
//   arp_fail, burst_done      sticky status, cleared by a tx_enable rising edge
//   frames_sent               frames completed in the current run
//   tx_state                  FSM state for debug: 0 idle, 1 req_arp, 2 wait_arprep, 3 send, 4 gap
//
// Optional build macro TX_SCHED_STATS_EN adds output tx_fps. It reports the number of
// frames completed during the last one-second interval.

module tx_frame_sched #(
  parameter logic [31:0] ARP_TIMEOUT   = 32'd156250000,
  parameter logic [3:0]  ARP_RETRY_MAX = 4'd3
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        tx_enable,
  input  logic        tx_req_arp,
  input  logic [31:0] inter_frame_gap,
  input  logic [31:0] burst_count,
  input  logic        arp_reply_valid,
  input  logic [47:0] arp_reply_mac,
  input  logic        arp_done,
  input  logic        frame_done,
  input  logic        sec_oneshot,
  output logic        arp_start,
  output logic        frame_start,
  output logic [47:0] tx0_dst_mac,
  output logic        dst_mac_valid,
  output logic        arp_fail,
  output logic        burst_done,
  output logic [31:0] frames_sent,
  output logic [2:0]  tx_state
`ifdef TX_SCHED_STATS_EN
  ,
  output logic [31:0] tx_fps
`endif
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StReqArp   = 3'd1,
    StWaitArp  = 3'd2,
    StSend     = 3'd3,
    StGap      = 3'd4
  } state_e;

  state_e      state_q;
  logic        en_q, req_q;
  logic [31:0] timer_q, gap_q;
  logic [3:0]  retry_q;

  logic        en_rise, req_rise;
  logic        bd_eff, af_eff, dmv_eff;
  logic [31:0] fs_eff, fs_inc;
  logic [3:0]  retry_nxt;

  // The "_eff" values are the sticky status after this cycle's edge-triggered clears.
  // Decisions use them, so a new run can leave IDLE on the same cycle the edge is seen.
  always_comb begin
    en_rise   = tx_enable & ~en_q;
    req_rise  = tx_req_arp & ~req_q;
    bd_eff    = burst_done & ~en_rise;
    af_eff    = arp_fail & ~en_rise;
    dmv_eff   = dst_mac_valid & ~req_rise;
    fs_eff    = en_rise ? 32'd0 : frames_sent;
    fs_inc    = fs_eff + 32'd1;
    retry_nxt = retry_q + 4'd1;
  end

  assign tx_state = state_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= StIdle;
      en_q          <= 1'b0;
      req_q         <= 1'b0;
      timer_q       <= '0;
      gap_q         <= '0;
      retry_q       <= '0;
      arp_start     <= 1'b0;
      frame_start   <= 1'b0;
      tx0_dst_mac   <= '1;
      dst_mac_valid <= 1'b0;
      arp_fail      <= 1'b0;
      burst_done    <= 1'b0;
      frames_sent   <= '0;
    end else begin
      en_q          <= tx_enable;
      req_q         <= tx_req_arp;
      arp_start     <= 1'b0;
      frame_start   <= 1'b0;
      burst_done    <= bd_eff;
      arp_fail      <= af_eff;
      frames_sent   <= fs_eff;
      dst_mac_valid <= dmv_eff;
      if (req_rise) tx0_dst_mac <= '1;

      case (state_q)
        StIdle: begin
          if (tx_enable && !bd_eff && !af_eff) begin
            if (tx_req_arp && !dmv_eff) begin
              state_q   <= StReqArp;
              retry_q   <= '0;
              arp_start <= 1'b1;
            end else begin
              state_q     <= StSend;
              frame_start <= 1'b1;
            end
          end
        end

        StReqArp: begin
          // The request frame is always allowed to finish, even if tx_enable dropped.
          if (arp_done) begin
            if (!tx_enable) begin
              state_q <= StIdle;
            end else begin
              timer_q <= ARP_TIMEOUT - 32'd1;
              state_q <= StWaitArp;
            end
          end
        end

        StWaitArp: begin
          if (!tx_enable) begin
            state_q <= StIdle;
          end else if (arp_reply_valid) begin
            // A reply on the last timer cycle still wins over the timeout.
            tx0_dst_mac   <= arp_reply_mac;
            dst_mac_valid <= 1'b1;
            state_q       <= StSend;
            frame_start   <= 1'b1;
          end else if (timer_q == 32'd0) begin
            retry_q <= retry_nxt;
            if (retry_nxt == ARP_RETRY_MAX) begin
              arp_fail <= 1'b1;
              state_q  <= StIdle;
            end else begin
              state_q   <= StReqArp;
              arp_start <= 1'b1;
            end
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end

        StSend: begin
          if (frame_done) begin
            frames_sent <= fs_inc;
            if (burst_count != 32'd0 && fs_inc == burst_count) begin
              burst_done <= 1'b1;
              state_q    <= StIdle;
            end else if (!tx_enable) begin
              state_q <= StIdle;
            end else if (inter_frame_gap == 32'd0) begin
              frame_start <= 1'b1;
            end else begin
              gap_q   <= inter_frame_gap - 32'd1;
              state_q <= StGap;
            end
          end
        end

        StGap: begin
          if (!tx_enable) begin
            state_q <= StIdle;
          end else if (gap_q == 32'd0) begin
            state_q     <= StSend;
            frame_start <= 1'b1;
          end else begin
            gap_q <= gap_q - 32'd1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef TX_SCHED_STATS_EN
  logic [31:0] fps_cnt_q;
  logic        frame_acc;

  assign frame_acc = (state_q == StSend) && frame_done;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      fps_cnt_q <= '0;
      tx_fps    <= '0;
    end else if (sec_oneshot) begin
      // A frame finishing on the boundary belongs to the new interval.
      tx_fps    <= fps_cnt_q;
      fps_cnt_q <= frame_acc ? 32'd1 : 32'd0;
    end else if (frame_acc) begin
      fps_cnt_q <= fps_cnt_q + 32'd1;
    end
  end
`else
  logic unused_sec_oneshot;
  assign unused_sec_oneshot = sec_oneshot;
`endif

endmodule

// File: tb/tb_tx_frame_sched.sv
module tb_tx_frame_sched;

  localparam int ArpTo = 20;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        tx_enable, tx_req_arp;
  logic [31:0] inter_frame_gap, burst_count;
  logic        arp_reply_valid;
  logic [47:0] arp_reply_mac;
  logic        arp_done, frame_done, sec_oneshot;
  logic        arp_start, frame_start;
  logic [47:0] tx0_dst_mac;
  logic        dst_mac_valid, arp_fail, burst_done;
  logic [31:0] frames_sent;
  logic [2:0]  tx_state;
`ifdef TX_SCHED_STATS_EN
  logic [31:0] tx_fps;
`endif

  tx_frame_sched #(
    .ARP_TIMEOUT  (32'd20),
    .ARP_RETRY_MAX(4'd3)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .tx_enable      (tx_enable),
    .tx_req_arp     (tx_req_arp),
    .inter_frame_gap(inter_frame_gap),
    .burst_count    (burst_count),
    .arp_reply_valid(arp_reply_valid),
    .arp_reply_mac  (arp_reply_mac),
    .arp_done       (arp_done),
    .frame_done     (frame_done),
    .sec_oneshot    (sec_oneshot),
    .arp_start      (arp_start),
    .frame_start    (frame_start),
    .tx0_dst_mac    (tx0_dst_mac),
    .dst_mac_valid  (dst_mac_valid),
    .arp_fail       (arp_fail),
    .burst_done     (burst_done),
    .frames_sent    (frames_sent),
    .tx_state       (tx_state)
`ifdef TX_SCHED_STATS_EN
    ,
    .tx_fps         (tx_fps)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Generator / RX responder settings and event logs.
  int lat = 5;
  int arp_lat = 4;
  bit reply_en = 0;
  int reply_dly = 15;
  logic [47:0] reply_mac = '0;
  int reply_cyc = -1;
  int start_q[$], done_q[$], astart_q[$], adone_q[$];

  // Responder: acts 1 time unit after each edge; the test acts 2 after.
  initial begin
    int fd_cnt, ad_cnt, rp_cnt;
    fd_cnt = 0; ad_cnt = 0; rp_cnt = 0;
    frame_done = 0; arp_done = 0; arp_reply_valid = 0; arp_reply_mac = '0;
    forever begin
      @(posedge sys_clk);
      #1;
      frame_done = 0; arp_done = 0; arp_reply_valid = 0;
      if (fd_cnt != 0) begin
        fd_cnt--;
        if (fd_cnt == 0) begin frame_done = 1; done_q.push_back(cyc); end
      end
      if (frame_start) begin fd_cnt = lat; start_q.push_back(cyc); end
      if (rp_cnt != 0) begin
        rp_cnt--;
        if (rp_cnt == 0) begin
          arp_reply_valid = 1; arp_reply_mac = reply_mac; reply_cyc = cyc;
        end
      end
      if (ad_cnt != 0) begin
        ad_cnt--;
        if (ad_cnt == 0) begin
          arp_done = 1; adone_q.push_back(cyc);
          if (reply_en) rp_cnt = reply_dly;
        end
      end
      if (arp_start) begin ad_cnt = arp_lat; astart_q.push_back(cyc); end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    start_q.delete(); done_q.delete(); astart_q.delete(); adone_q.delete();
  endtask

  // One burst from IDLE; start times follow from L, G: start_k = first + k*(L+G+1).
  task automatic run_burst(input string tag, input int g, input int b, input int l,
                           input int exp_span);
    int e, n;
    tx_enable = 0;
    repeat (3) tick();
    inter_frame_gap = g; burst_count = b; lat = l;
    clear_logs();
    tx_enable = 1; e = cyc;
    tick();
    n = 0;
    while (!burst_done && n < 1000) begin tick(); n++; end
    check($sformatf("%s finished", tag), 64'(n < 1000), 1);
    check($sformatf("%s starts", tag), start_q.size(), b);
    check($sformatf("%s dones", tag), done_q.size(), b);
    for (int k = 0; k < start_q.size() && k < b; k++)
      check($sformatf("%s start%0d", tag, k), start_q[k], e + 1 + k * (l + g + 1));
    if (done_q.size() == b && start_q.size() != 0)
      check($sformatf("%s span", tag), done_q[b-1] - start_q[0], exp_span);
    check($sformatf("%s frames_sent", tag), frames_sent, b);
    check($sformatf("%s burst_done", tag), burst_done, 1);
    check($sformatf("%s state", tag), tx_state, 0);
    repeat (10) tick();
    check($sformatf("%s no_restart", tag), start_q.size(), b);
  endtask

  typedef struct {
    int gap;
    int burst;
    int lat;
    int span;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int e, n, d, g, b, l;
    tbl[0] = '{0, 3, 5, 17};
    tbl[1] = '{10, 2, 5, 21};
    tbl[2] = '{1, 4, 1, 10};
    tbl[3] = '{2, 3, 4, 18};
    tbl[4] = '{4, 1, 2, 2};

    sys_rst = 1; tx_enable = 0; tx_req_arp = 0; inter_frame_gap = 0; burst_count = 0;
    sec_oneshot = 0;
    repeat (3) tick();
    sys_rst = 0;
    tick();
    check("rst tx_state", tx_state, 0);
    check("rst mac", tx0_dst_mac, 48'hffffffffffff);
    check("rst flags", {arp_start, frame_start, dst_mac_valid, arp_fail, burst_done}, 0);
    check("rst frames_sent", frames_sent, 0);

    for (int i = 0; i < 5; i++)
      run_burst($sformatf("tbl%0d", i), tbl[i].gap, tbl[i].burst, tbl[i].lat, tbl[i].span);

    // ARP resolve, reply well inside the timeout.
    tx_enable = 0; tx_req_arp = 1; inter_frame_gap = 0; burst_count = 1; lat = 5;
    reply_en = 1; reply_dly = 15; reply_mac = 48'h001122334455;
    tick();
    clear_logs();
    tx_enable = 1; e = cyc;
    tick(); n = 0;
    while (!burst_done && n < 300) begin tick(); n++; end
    check("arp finished", 64'(n < 300), 1);
    check("arp starts", astart_q.size(), 1);
    if (astart_q.size() != 0) check("arp start cyc", astart_q[0], e + 1);
    check("arp mac", tx0_dst_mac, 48'h001122334455);
    check("arp valid", dst_mac_valid, 1);
    check("arp frames", start_q.size(), 1);
    if (start_q.size() != 0) check("arp frame after reply", start_q[0], reply_cyc + 1);

    // Rising tx_req_arp forgets the cached MAC.
    tx_enable = 0; tx_req_arp = 0;
    tick();
    tx_req_arp = 1;
    tick(); tick();
    check("reqrise valid", dst_mac_valid, 0);
    check("reqrise mac", tx0_dst_mac, 48'hffffffffffff);

    // Reply on the final timer cycle wins over the timeout.
    reply_dly = ArpTo; reply_mac = 48'ha1b2c3d4e5f6;
    clear_logs();
    tx_enable = 1;
    tick(); n = 0;
    while (!burst_done && n < 300) begin tick(); n++; end
    check("late reply finished", 64'(n < 300), 1);
    check("late reply arp starts", astart_q.size(), 1);
    check("late reply mac", tx0_dst_mac, 48'ha1b2c3d4e5f6);
    check("late reply fail", arp_fail, 0);
    if (start_q.size() != 0) check("late reply frame", start_q[0], reply_cyc + 1);

    // No reply: three requests, each ArpTo+1 cycles after the previous arp_done, then fail.
    tx_enable = 0; tx_req_arp = 0; reply_en = 0;
    tick();
    tx_req_arp = 1;
    tick();
    clear_logs();
    tx_enable = 1; e = cyc;
    tick(); n = 0;
    while (!arp_fail && n < 300) begin tick(); n++; end
    check("timeout finished", 64'(n < 300), 1);
    check("timeout arp starts", astart_q.size(), 3);
    if (astart_q.size() != 0) check("timeout first start", astart_q[0], e + 1);
    for (int k = 0; k + 1 < astart_q.size() && k < adone_q.size(); k++)
      check($sformatf("timeout retry%0d", k), astart_q[k+1] - adone_q[k], ArpTo + 1);
    check("timeout no frame", start_q.size(), 0);
    check("timeout state", tx_state, 0);
    repeat (10) tick();
    check("timeout held", astart_q.size(), 3);

    // Drop tx_enable mid-SEND.
    tx_enable = 0; tx_req_arp = 0;
    tick();
    inter_frame_gap = 0; burst_count = 0; lat = 5;
    clear_logs();
    tx_enable = 1;
    n = 0;
    while (start_q.size() == 0 && n < 20) begin tick(); n++; end
    tick(); tick();
    tx_enable = 0;
    n = 0;
    while (done_q.size() == 0 && n < 20) begin tick(); n++; end
    check("drop send done seen", 64'(n < 20), 1);
    check("drop send in send", tx_state, 3);
    tick();
    check("drop send idle", tx_state, 0);
    check("drop send frames", frames_sent, 1);
    repeat (20) tick();
    check("drop send no restart", start_q.size(), 1);

    // Drop tx_enable in GAP.
    inter_frame_gap = 10; lat = 3;
    clear_logs();
    tx_enable = 1;
    n = 0;
    while (done_q.size() == 0 && n < 30) begin tick(); n++; end
    d = cyc;
    tick(); tick();
    check("drop gap in gap", tx_state, 4);
    check("drop gap cyc", cyc - d, 2);
    tx_enable = 0;
    tick();
    check("drop gap idle", tx_state, 0);
    repeat (20) tick();
    check("drop gap no restart", start_q.size(), 1);

    // Randomised bursts against the arithmetic model.
    for (int i = 0; i < 8; i++) begin
      g = $urandom_range(0, 6);
      b = $urandom_range(1, 5);
      l = $urandom_range(1, 6);
      run_burst($sformatf("rnd%0d g%0d b%0d l%0d", i, g, b, l), g, b, l,
                b * l + (b - 1) * (g + 1));
    end

`ifdef TX_SCHED_STATS_EN
    tx_enable = 0;
    tick();
    sec_oneshot = 1;
    tick();
    sec_oneshot = 0;
    run_burst("fps", 0, 7, 2, 20);
    sec_oneshot = 1;
    tick();
    sec_oneshot = 0;
    tick();
    check("tx_fps", tx_fps, 7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
